// File: rtl/sparse_pkg.sv
// Shared sizing, beat type and FSM encoding for the sparse chunk writer path.
// Sizes mirror the global chunk-store macros when they are defined.
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef CHUNK_SIZE
`define CHUNK_SIZE 16
`endif

package sparse_pkg;
   localparam int BUS_SIZE   = `BUS_SIZE;
   localparam int CHUNK_SIZE = `CHUNK_SIZE;
   localparam int BEATS      = CHUNK_SIZE / BUS_SIZE;

   typedef logic [BUS_SIZE-1:0][7:0] beat_t;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;
endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational per-beat compaction: nonzero mask, popcount and the nonzero
// bytes left-packed in ascending byte order, zero-filled above the popcount.
module sparse_beat_compactor #(
   parameter int BUS_SIZE = sparse_pkg::BUS_SIZE
) (
   input  logic [BUS_SIZE-1:0][7:0]     beat,
   output logic [BUS_SIZE-1:0]          mask,
   output logic [$clog2(BUS_SIZE):0]    popcnt,
   output logic [BUS_SIZE-1:0][7:0]     pk_bytes
);
   localparam int PW = $clog2(BUS_SIZE);

   // popcnt doubles as the running prefix sum that picks each byte's slot
   always_comb begin
      mask     = '0;
      popcnt   = '0;
      pk_bytes = '0;
      for (int b = 0; b < BUS_SIZE; b++) begin
         mask[b] = (beat[b] != 8'h00);
         if (mask[b]) begin
            pk_bytes[popcnt[PW-1:0]] = beat[b];
            popcnt = popcnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/sparse_chunk_encoder.sv
// Dense-to-sparse chunk encoder: compacts BEATS input beats into a chunk buffer,
// then streams sparsemap slices and compacted bytes to the chunk store.
module sparse_chunk_encoder #(
   parameter int BUS_SIZE   = sparse_pkg::BUS_SIZE,
   parameter int CHUNK_SIZE = sparse_pkg::CHUNK_SIZE,
   parameter int BEATS      = CHUNK_SIZE / BUS_SIZE
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [BUS_SIZE-1:0][7:0]      in_data_i,
   output logic [BUS_SIZE-1:0]           wr_sparsemap_o,
   output logic [BUS_SIZE-1:0][7:0]      wr_nonzero_data_o,
   output logic                          wr_valid_o,
   output logic [$clog2(BEATS)-1:0]      wr_count_o,
   output logic                          done_o,
   output logic [$clog2(CHUNK_SIZE):0]   nnz_o
);
   localparam int BW = $clog2(BEATS);
   localparam int NW = $clog2(CHUNK_SIZE) + 1;
   localparam int AW = $clog2(CHUNK_SIZE);
   localparam int CW = $clog2(BUS_SIZE) + 1;

   sparse_pkg::state_e              state;
   logic [BW-1:0]                   in_cnt, out_cnt;
   logic [NW-1:0]                   nnz, base;
   logic [CHUNK_SIZE-1:0]           smap;
   logic [CHUNK_SIZE-1:0][7:0]      chunk_buf;
   logic                            done_q, accept;
   logic [BUS_SIZE-1:0]             beat_mask;
   logic [CW-1:0]                   beat_pc;
   logic [BUS_SIZE-1:0][7:0]        beat_pk;

   sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
      .beat     (in_data_i),
      .mask     (beat_mask),
      .popcnt   (beat_pc),
      .pk_bytes (beat_pk)
   );

   assign accept = in_valid_i && (state == sparse_pkg::FILL);
   // beat 0 restarts the count so the previous chunk's nnz stays visible until then
   assign base   = (in_cnt == '0) ? '0 : nnz;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= sparse_pkg::FILL;
         in_cnt  <= '0;
         out_cnt <= '0;
         nnz     <= '0;
         smap    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            sparse_pkg::FILL: if (accept) begin
               smap[BUS_SIZE*in_cnt +: BUS_SIZE] <= beat_mask;
               nnz <= base + NW'(beat_pc);
               if (in_cnt == BW'(BEATS-1)) begin
                  state   <= sparse_pkg::DRAIN;
                  in_cnt  <= '0;
                  out_cnt <= '0;
               end else begin
                  in_cnt <= in_cnt + 1'b1;
               end
            end
            sparse_pkg::DRAIN: begin
               if (out_cnt == BW'(BEATS-1)) begin
                  state   <= sparse_pkg::FILL;
                  out_cnt <= '0;
                  done_q  <= 1'b1;
               end else begin
                  out_cnt <= out_cnt + 1'b1;
               end
            end
            default: state <= sparse_pkg::FILL;
         endcase
      end
   end

   // Data storage needs no reset: reads are masked by nnz.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         for (int i = 0; i < BUS_SIZE; i++)
            if (i < int'(beat_pc))
               chunk_buf[AW'(int'(base) + i)] <= beat_pk[i];
      end
   end

   assign in_ready_o = (state == sparse_pkg::FILL);
   assign wr_valid_o = (state == sparse_pkg::DRAIN);
   assign wr_count_o = out_cnt;
   assign done_o     = done_q;
   assign nnz_o      = nnz;

   always_comb begin
      wr_sparsemap_o    = '0;
      wr_nonzero_data_o = '0;
      if (state == sparse_pkg::DRAIN) begin
         wr_sparsemap_o = smap[BUS_SIZE*out_cnt +: BUS_SIZE];
         for (int b = 0; b < BUS_SIZE; b++)
            if (BUS_SIZE*int'(out_cnt) + b < int'(nnz))
               wr_nonzero_data_o[b] = chunk_buf[AW'(BUS_SIZE*int'(out_cnt) + b)];
      end
   end
endmodule

// File: doc/sparse_chunk_encoder.md
# sparse_chunk_encoder

Converts a dense byte stream into the sparse chunk format held by the chunk store: one sparsemap bit per byte plus a 1-indexed, globally compacted array of nonzero bytes. Accepts one chunk as `WR_DAT_CYC_NUM` dense beats over a valid/ready handshake and compacts each beat into an internal chunk buffer. It then drives the chunk store's write port (`wr_sparsemap`, `wr_nonzero_data`, `wr_valid`, `wr_count`) in `WR_DAT_CYC_NUM` back-to-back beats. It is the writer side of the chunk store, placed between the activation/weight producer and the store.

## Interface
Parameters:
- `BUS_SIZE`, default `` `BUS_SIZE ``: bytes per beat.
- `CHUNK_SIZE`, default `` `CHUNK_SIZE ``: bytes per chunk. Must be a multiple of `BUS_SIZE`.
- `BEATS`, default `CHUNK_SIZE/BUS_SIZE`: number of beats per chunk (equals `` `WR_DAT_CYC_NUM ``).

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  a dense beat is offered.
- `in_ready_o`  out  1  the encoder can accept a dense beat.
- `in_data_i`  in  `[BUS_SIZE-1:0][7:0]`  dense bytes; byte 0 is the lowest chunk index.
- `wr_sparsemap_o`  out  `BUS_SIZE`  sparsemap slice for beat `wr_count_o`.
- `wr_nonzero_data_o`  out  `[BUS_SIZE-1:0][7:0]`  compacted bytes `BUS_SIZE*k+1 .. BUS_SIZE*(k+1)`.
- `wr_valid_o`  out  1  write strobe to the chunk store. There is no backpressure.
- `wr_count_o`  out  `$clog2(BEATS)`  beat index `k`.
- `done_o`  out  1  one-cycle pulse after the last write beat.
- `nnz_o`  out  `$clog2(CHUNK_SIZE)+1`  nonzero count of the chunk just written. Valid while `done_o` is high and held until the next chunk starts.

## Operation
- FSM states: `FILL` (reset state) and `DRAIN`.
- **FILL**
  - `in_ready_o = 1`. A beat is accepted when `in_valid_i && in_ready_o`.
  - On acceptance of in-beat `j`:
    - `smap[BUS_SIZE*j +: BUS_SIZE][b] = (in_data_i[b] != 8'h00)`.
    - The nonzero bytes of the beat, in ascending `b` order, are written to `buf[nnz+1 ..]`.
    - `nnz += popcount(beat)`.
    - `in_cnt++`.
  - Acceptance of beat `BEATS-1` moves the FSM to `DRAIN`, with `out_cnt = 0`.
  - When `in_cnt == 0`, a new chunk starts: acceptance of beat 0 sets `nnz` to the beat popcount, and `nnz_o` switches to track the new count.
- **DRAIN**
  - `in_ready_o = 0`. `in_valid_i` is ignored and no data is lost.
  - Each cycle:
    - `wr_valid_o = 1`, `wr_count_o = out_cnt`.
    - `wr_sparsemap_o = smap[BUS_SIZE*out_cnt +: BUS_SIZE]`.
    - `wr_nonzero_data_o` byte `b` = `buf[BUS_SIZE*out_cnt+1+b]` if that index is `<= nnz`, otherwise `8'h00`. Stale buffer contents therefore never reach the store.
  - After `out_cnt == BEATS-1`, the FSM returns to `FILL`, `in_cnt` resets to 0, and `done_o` pulses.
- Arithmetic: `nnz` ranges 0..`CHUNK_SIZE` inclusive and never wraps. Within-beat prefix sums are `$clog2(BUS_SIZE)+1` bits wide.
- Asynchronous reset, which may arrive mid-chunk or mid-drain, discards the partial chunk and forces:
  - state `FILL`;
  - `in_cnt = out_cnt = 0`, `nnz = 0`, `smap = 0`;
  - all outputs 0 except `in_ready_o`, which is 1 after reset is released.

## Timing
- Input: one beat per cycle at full rate. There is no combinational path from `in_valid_i` to `in_ready_o`.
- The cycle after the last input beat is accepted, write beat 0 is driven. Beats 0..`BEATS-1` are driven on consecutive cycles.
- `done_o` is high in the cycle after write beat `BEATS-1`, and `in_ready_o` is high in that same cycle.
- Chunk period is `2*BEATS` cycles when the input is always valid.
- All outputs are registered or decoded from registered state only.

## Structure
- Shared package `sparse_pkg` holds:
  - `BUS_SIZE`, `CHUNK_SIZE` and `BEATS`, mirroring the global macros;
  - `typedef logic [BUS_SIZE-1:0][7:0] beat_t`;
  - the FSM `enum`.
- One sub-module, `sparse_beat_compactor`, which is purely combinational.
  - Inputs: `beat_t`.
  - Outputs: the nonzero mask, the popcount, and the left-packed nonzero bytes (zero-filled).
  - The top-level block places these packed bytes at offset `nnz+1`.

## Test plan
All scenarios use `BUS_SIZE=4`, `CHUNK_SIZE=16`, `BEATS=4`.
1. **All-zero chunk, 4 beats:**
   - writes carry `wr_count_o` 0,1,2,3, each with sparsemap `4'h0` and data all `00`;
   - `done_o` pulses with `nnz_o=0`.
2. **Dense chunk with bytes 1..16:**
   - every sparsemap slice is `4'hF`;
   - data beat k = bytes `{4k+1..4k+4}`;
   - `nnz_o=16`.
3. **Beat 0 = `{00,05,00,07}`, beat 1 = `{09,00,00,00}`, beats 2-3 all zero:**
   - sparsemap slices are `4'hA`, `4'h1`, `0`, `0`;
   - data beat 0 = `{05,07,09,00}`, beats 1-3 all `00`;
   - `nnz_o=3`.
4. **Backpressure and idle gaps:**
   - `in_valid_i` toggled randomly, and held high during `DRAIN`;
   - `in_ready_o` is low for exactly 4 cycles, and no input beat is dropped or duplicated.
5. **Reset asserted after 2 accepted beats:**
   - all outputs clear immediately;
   - a following all-`FF` chunk yields `nnz_o=16` with no residue from the aborted chunk.
6. **Back-to-back chunks A (nnz 10), then B (nnz 2):**
   - B's data bytes beyond index 2 read `00`, even though A left stale bytes in the buffer;
   - `nnz_o=2`.
